// File: rtl/lc3_mem_arbiter_if.sv
// Bus bundle between the LC-3 requesters (CPU, loader), the memory array and the arbiter.
// The arbiter takes the slave view; requesters plus memory take the master view.
interface lc3_mem_arbiter_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_gnt;
   logic              cpu_done;
   logic              ldr_req;
   logic              ldr_we;
   logic [ADDR_W-1:0] ldr_addr;
   logic [DATA_W-1:0] ldr_wdata;
   logic              ldr_gnt;
   logic              ldr_done;
   logic [DATA_W-1:0] rdata;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
      input  mem_rdata,
      output cpu_gnt, cpu_done, ldr_gnt, ldr_done, rdata,
      output mem_en, mem_we, mem_addr, mem_wdata, busy
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output ldr_req, ldr_we, ldr_addr, ldr_wdata,
      output mem_rdata,
      input  cpu_gnt, cpu_done, ldr_gnt, ldr_done, rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/lc3_mem_arbiter.sv
// Two-port arbiter for the LC-3 single-port memory: CPU wins by default, the loader is
// guaranteed a slot after STARVE_MAX consecutive CPU grants. All outputs are registered.
module lc3_mem_arbiter #(
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input logic              clk,
   input logic              reset,
   lc3_mem_arbiter_if.slave bus
);
   localparam int unsigned SW = $clog2(STARVE_MAX + 1);
   // WAIT lasts MEM_LAT-1 cycles so that DONE lands MEM_LAT cycles after ISSUE.
   localparam logic [3:0] LatLoad = (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

   state_e        state_q;
   logic          sel_ldr_q;
   logic          we_q;
   logic [3:0]    lat_q;
   logic [SW-1:0] starve_q;
   logic          ldr_wins;
   logic          go_done;

   always_comb begin
      ldr_wins = bus.ldr_req & (~bus.cpu_req | (starve_q == SW'(STARVE_MAX)));
      go_done  = ((state_q == StIssue) && (we_q || (MEM_LAT == 1))) ||
                 ((state_q == StWait) && (lat_q == 4'd0));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         sel_ldr_q     <= 1'b0;
         we_q          <= 1'b0;
         lat_q         <= 4'd0;
         starve_q      <= '0;
         bus.cpu_gnt   <= 1'b0;
         bus.cpu_done  <= 1'b0;
         bus.ldr_gnt   <= 1'b0;
         bus.ldr_done  <= 1'b0;
         bus.rdata     <= '0;
         bus.mem_en    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.busy      <= 1'b0;
      end else begin
         bus.cpu_gnt  <= 1'b0;
         bus.ldr_gnt  <= 1'b0;
         bus.cpu_done <= 1'b0;
         bus.ldr_done <= 1'b0;
         bus.mem_en   <= 1'b0;
         bus.mem_we   <= 1'b0;

         unique case (state_q)
            StIdle: begin
               if (!bus.ldr_req) starve_q <= '0;
               if (bus.cpu_req || bus.ldr_req) begin
                  state_q   <= StIssue;
                  bus.busy  <= 1'b1;
                  bus.mem_en <= 1'b1;
                  sel_ldr_q <= ldr_wins;
                  if (ldr_wins) begin
                     we_q          <= bus.ldr_we;
                     bus.mem_we    <= bus.ldr_we;
                     bus.mem_addr  <= bus.ldr_addr;
                     bus.mem_wdata <= bus.ldr_wdata;
                     bus.ldr_gnt   <= 1'b1;
                     starve_q      <= '0;
                  end else begin
                     we_q          <= bus.cpu_we;
                     bus.mem_we    <= bus.cpu_we;
                     bus.mem_addr  <= bus.cpu_addr;
                     bus.mem_wdata <= bus.cpu_wdata;
                     bus.cpu_gnt   <= 1'b1;
                     if (bus.ldr_req) starve_q <= starve_q + SW'(1);
                  end
               end
            end
            StIssue: begin
               if (!go_done) begin
                  state_q <= StWait;
                  lat_q   <= LatLoad;
               end
            end
            StWait: begin
               if (!go_done) lat_q <= lat_q - 4'd1;
            end
            StDone: begin
               state_q  <= StIdle;
               bus.busy <= 1'b0;
            end
         endcase

         // Entry into DONE: pulse the winner's done and capture read data on the same edge.
         if (go_done) begin
            state_q      <= StDone;
            bus.cpu_done <= ~sel_ldr_q;
            bus.ldr_done <= sel_ldr_q;
            if (!we_q) bus.rdata <= bus.mem_rdata;
         end
      end
   end
endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter: table of single transactions on a MEM_LAT=2 instance,
// plus hand sequences for starvation, reset abort, ignored pulses and a MEM_LAT=1 instance.
module tb_lc3_mem_arbiter;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   lc3_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus_a ();
   lc3_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus_b ();

   lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2), .STARVE_MAX(4)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a)
   );
   lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .STARVE_MAX(4)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b)
   );

   // Asynchronous-read memories; location 0x00 of mem_a comes out of reset as 16'h1234.
   logic [15:0] mem_a [256];
   logic [15:0] mem_b [256];
   assign bus_a.mem_rdata = mem_a[bus_a.mem_addr[7:0]];
   assign bus_b.mem_rdata = mem_b[bus_b.mem_addr[7:0]];
   always @(posedge clk) begin
      if (reset) mem_a[8'h00] <= 16'h1234;
      else if (bus_a.mem_en && bus_a.mem_we) mem_a[bus_a.mem_addr[7:0]] <= bus_a.mem_wdata;
      if (bus_b.mem_en && bus_b.mem_we) mem_b[bus_b.mem_addr[7:0]] <= bus_b.mem_wdata;
   end

   int n_pass = 0;
   int n_total = 0;
   bit dual_viol = 1'b0;
   bit we_viol = 1'b0;

   always @(negedge clk) begin
      if ((bus_a.cpu_gnt && bus_a.ldr_gnt) || (bus_a.cpu_done && bus_a.ldr_done)) dual_viol = 1'b1;
      if ((bus_a.mem_we && !bus_a.mem_en) || (bus_b.mem_we && !bus_b.mem_en)) we_viol = 1'b1;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   typedef struct {
      bit          ldr;
      bit          we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_rdata;  // read result, or the held value after a write
   } vec_t;

   // Called in an IDLE cycle; returns in the IDLE cycle after the transaction.
   task automatic run_txn(input vec_t v, input int idx);
      int gnt_cyc = -1;
      int done_cyc = -1;
      if (v.ldr) begin
         bus_a.ldr_req = 1'b1; bus_a.ldr_we = v.we; bus_a.ldr_addr = v.addr;
         bus_a.ldr_wdata = v.wdata;
      end else begin
         bus_a.cpu_req = 1'b1; bus_a.cpu_we = v.we; bus_a.cpu_addr = v.addr;
         bus_a.cpu_wdata = v.wdata;
      end
      for (int cyc = 1; cyc <= 20 && done_cyc < 0; cyc++) begin
         @(posedge clk); #1;
         if ((v.ldr ? bus_a.ldr_gnt : bus_a.cpu_gnt) && gnt_cyc < 0) gnt_cyc = cyc;
         if (v.ldr ? bus_a.ldr_done : bus_a.cpu_done) done_cyc = cyc;
      end
      bus_a.cpu_req = 1'b0;
      bus_a.ldr_req = 1'b0;
      check($sformatf("vec%0d gnt latency", idx), 64'(gnt_cyc), 64'd1);
      check($sformatf("vec%0d done latency", idx), 64'(done_cyc), v.we ? 64'd2 : 64'd3);
      check($sformatf("vec%0d rdata", idx), 64'(bus_a.rdata), 64'(v.exp_rdata));
      @(posedge clk); #1;
   endtask

   function automatic logic [63:0] outs_a();
      return 64'({bus_a.cpu_gnt, bus_a.cpu_done, bus_a.ldr_gnt, bus_a.ldr_done, bus_a.rdata,
                  bus_a.mem_en, bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata, bus_a.busy});
   endfunction

   function automatic logic [63:0] outs_b();
      return 64'({bus_b.cpu_gnt, bus_b.cpu_done, bus_b.ldr_gnt, bus_b.ldr_done, bus_b.rdata,
                  bus_b.mem_en, bus_b.mem_we, bus_b.mem_addr, bus_b.mem_wdata, bus_b.busy});
   endfunction

   initial begin
      vec_t vecs [10];
      logic [9:0] order;
      int n_gnt, cyc, k;
      bit seen_a, seen_b;
      int gnt_c [4];
      int done_c [4];
      logic [15:0] rd [4];

      vecs[0] = '{0, 0, 16'h3000, 16'h0000, 16'h1234};
      vecs[1] = '{1, 1, 16'h3001, 16'hABCD, 16'h1234};
      vecs[2] = '{0, 0, 16'h3001, 16'h0000, 16'hABCD};
      vecs[3] = '{0, 1, 16'h3002, 16'h5A5A, 16'hABCD};
      vecs[4] = '{1, 0, 16'h3002, 16'h0000, 16'h5A5A};
      vecs[5] = '{1, 0, 16'h3000, 16'h0000, 16'h1234};
      vecs[6] = '{0, 1, 16'h30FF, 16'hFFFF, 16'h1234};
      vecs[7] = '{0, 0, 16'h30FF, 16'h0000, 16'hFFFF};
      vecs[8] = '{1, 1, 16'h3000, 16'h0000, 16'hFFFF};
      vecs[9] = '{0, 0, 16'h3000, 16'h0000, 16'h0000};

      {bus_a.cpu_req, bus_a.cpu_we, bus_a.cpu_addr, bus_a.cpu_wdata} = '0;
      {bus_a.ldr_req, bus_a.ldr_we, bus_a.ldr_addr, bus_a.ldr_wdata} = '0;
      {bus_b.cpu_req, bus_b.cpu_we, bus_b.cpu_addr, bus_b.cpu_wdata} = '0;
      {bus_b.ldr_req, bus_b.ldr_we, bus_b.ldr_addr, bus_b.ldr_wdata} = '0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset outputs A", outs_a(), 64'd0);
      check("reset outputs B", outs_b(), 64'd0);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) run_txn(vecs[i], i);

      // Both ports requesting continuously: loader gets every fifth slot.
      bus_a.cpu_req = 1'b1; bus_a.cpu_we = 1'b0; bus_a.cpu_addr = 16'h3000;
      bus_a.ldr_req = 1'b1; bus_a.ldr_we = 1'b0; bus_a.ldr_addr = 16'h3001;
      order = '0;
      n_gnt = 0;
      for (cyc = 0; cyc < 200 && n_gnt < 10; cyc++) begin
         @(posedge clk); #1;
         if (bus_a.cpu_gnt || bus_a.ldr_gnt) begin
            order = {order[8:0], bus_a.ldr_gnt};
            n_gnt++;
         end
      end
      check("starvation grant order", 64'(order), 64'h021);
      check("starvation grant count", 64'(n_gnt), 64'd10);
      bus_a.cpu_req = 1'b0;
      bus_a.ldr_req = 1'b0;
      for (cyc = 0; cyc < 20 && bus_a.busy; cyc++) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #1;

      // Loader pulse while a CPU read is in WAIT must be ignored.
      bus_a.cpu_req = 1'b1; bus_a.cpu_we = 1'b0; bus_a.cpu_addr = 16'h3002;
      @(posedge clk); #1;
      check("pulse cpu_gnt", 64'(bus_a.cpu_gnt), 64'd1);
      @(posedge clk); #1;
      bus_a.ldr_req = 1'b1; bus_a.ldr_we = 1'b1; bus_a.ldr_addr = 16'h3002;
      bus_a.ldr_wdata = 16'hDEAD;
      @(posedge clk); #1;
      bus_a.ldr_req = 1'b0;
      bus_a.cpu_req = 1'b0;
      check("pulse cpu_done", 64'(bus_a.cpu_done), 64'd1);
      check("pulse rdata", 64'(bus_a.rdata), 64'h5A5A);
      seen_a = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (bus_a.ldr_gnt || bus_a.mem_en) seen_a = 1'b1;
      end
      check("pulse no ldr_gnt", 64'(seen_a), 64'd0);
      check("pulse starve_cnt", 64'(dut_a.starve_q), 64'd0);

      // Reset in WAIT aborts the read without a done pulse.
      bus_a.cpu_req = 1'b1; bus_a.cpu_we = 1'b0; bus_a.cpu_addr = 16'h3001;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("abort busy in wait", 64'(bus_a.busy), 64'd1);
      reset = 1'b1;
      bus_a.cpu_req = 1'b0;
      @(posedge clk); #1;
      check("abort outputs zero", outs_a(), 64'd0);
      reset = 1'b0;
      seen_a = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (bus_a.cpu_done || bus_a.mem_en) seen_a = 1'b1;
      end
      check("abort no done or access", 64'(seen_a), 64'd0);

      // MEM_LAT=1: write/read pairs with the request held across transactions.
      bus_b.cpu_req = 1'b1; bus_b.cpu_we = 1'b1; bus_b.cpu_addr = 16'h3010;
      bus_b.cpu_wdata = 16'h1111;
      k = 0;
      seen_b = 1'b0;
      for (int i = 0; i < 4; i++) begin
         gnt_c[i] = -1; done_c[i] = -1; rd[i] = '0;
      end
      for (cyc = 1; cyc < 100 && k < 4; cyc++) begin
         @(posedge clk); #1;
         if (bus_b.cpu_gnt) gnt_c[k] = cyc;
         if (bus_b.cpu_done) begin
            done_c[k] = cyc;
            rd[k] = bus_b.rdata;
            k++;
            unique case (k)
               1: bus_b.cpu_we = 1'b0;
               2: begin
                  bus_b.cpu_we = 1'b1; bus_b.cpu_addr = 16'h3011; bus_b.cpu_wdata = 16'h2222;
               end
               3: bus_b.cpu_we = 1'b0;
               default: bus_b.cpu_req = 1'b0;
            endcase
         end
      end
      for (int i = 0; i < 4; i++) begin
         check($sformatf("lat1 txn%0d gnt cycle", i), 64'(gnt_c[i]), 64'(1 + 3 * i));
         check($sformatf("lat1 txn%0d done cycle", i), 64'(done_c[i]), 64'(2 + 3 * i));
      end
      check("lat1 read 3010", 64'(rd[1]), 64'h1111);
      check("lat1 read 3011", 64'(rd[3]), 64'h2222);
      @(posedge clk); #1;
      check("lat1 idle after", 64'(bus_b.busy), 64'd0);

      check("no simultaneous gnt/done", 64'(dual_viol), 64'd0);
      check("mem_we only with mem_en", 64'(we_viol), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
